// File: rtl/audio_pkg.sv
// Shared types and helpers for the codec sample path.
//   CODEC_W       : audio_codec word width (24)
//   codec_word_t  : signed codec word
//   wr_state_t    : DAC writer state (PREFILL / STREAM)
//   to_codec_word : left-justify an n-bit sample (already sign-extended
//                   to CODEC_W) into the codec word, low bits zero
package audio_pkg;
  localparam int CODEC_W = 24;

  typedef logic signed [CODEC_W-1:0] codec_word_t;

  typedef enum logic {PREFILL = 1'b0, STREAM = 1'b1} wr_state_t;

  // Exact inverse of capture truncation: the sample lands in bits
  // [CODEC_W-1 -: n] and the rest are zero; no rounding.
  function automatic codec_word_t to_codec_word(input codec_word_t s,
                                                input int unsigned n);
    return codec_word_t'(s <<< (CODEC_W - n));
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with first-word-fall-through head.
//   clk, rst    : clock, synchronous active-high reset (empties FIFO)
//   push, wdata : store wdata this edge (caller guarantees !full)
//   pop         : drop head this edge (caller guarantees !empty)
//   head        : current head sample (combinational read)
//   level       : occupancy 0..DEPTH, tracked independently of pointers
//   full, empty : occupancy flags
module sample_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [N-1:0]  wdata,
  input  logic          pop,
  output logic [N-1:0]  head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Storage needs no reset; pointers/level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo DEPTH
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/codec_sample_writer.sv
// Playback writer: buffers mono N-bit samples and feeds the audio_codec
// DAC write handshake, duplicating each widened sample to both channels.
//   clk, rst          : clock, synchronous active-high reset
//   inSample/inValid/inReady : producer sample stream
//   mute              : zero DAC data (FIFO still drains)
//   write_ready/write : codec DAC handshake, write = write_ready & ~rst
//   writedata_left/right : 24-bit DAC words (identical)
//   level             : FIFO occupancy
//   underrunCount     : saturating underrun event count
//   streaming         : state == STREAM
module codec_sample_writer
  import audio_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       inSample,
  input  logic               inValid,
  output logic               inReady,
  input  logic               mute,
  input  logic               write_ready,
  output logic               write,
  output logic [CODEC_W-1:0] writedata_left,
  output logic [CODEC_W-1:0] writedata_right,
  output logic [AW:0]        level,
  output logic [15:0]        underrunCount,
  output logic               streaming
);
  wr_state_t   state, state_nxt;
  logic        push, pop, underrun, full, empty;
  logic [N-1:0] head;
  codec_word_t word;

  assign inReady = ~rst & ~full;
  assign push    = inValid & inReady;
  assign write   = write_ready & ~rst;

  sample_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (inSample),
    .pop   (pop),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= PREFILL;
    else     state <= state_nxt;
  end

  // Word defaults to zero; only a non-empty STREAM transfer carries data.
  // An empty transfer is an underrun even if a push lands the same cycle:
  // the pushed sample goes into the FIFO, it is never forwarded.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    underrun  = 1'b0;
    word      = '0;
    case (state)
      PREFILL: begin
        if (level >= (AW+1)'(DEPTH/2)) state_nxt = STREAM;
      end
      STREAM: begin
        if (write) begin
          if (empty) begin
            underrun  = 1'b1;
            state_nxt = PREFILL;
          end else begin
            pop = 1'b1;
            if (!mute) word = to_codec_word(codec_word_t'(signed'(head)), N);
          end
        end
      end
      default: state_nxt = PREFILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      underrunCount <= '0;
    else if (underrun && underrunCount != 16'hFFFF)
      underrunCount <= underrunCount + 16'd1;
  end

  assign writedata_left  = word;
  assign writedata_right = word;
  assign streaming       = (state == STREAM);
endmodule

// File: tb/tb_codec_sample_writer.sv
module tb_codec_sample_writer;
  logic        clk = 1'b0;
  logic        rst, inValid, inReady, mute, write_ready, write, streaming;
  logic [15:0] inSample, underrunCount;
  logic [23:0] writedata_left, writedata_right;
  logic [4:0]  level;
  int tests = 0, fails = 0;

  codec_sample_writer #(.N(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .inSample(inSample), .inValid(inValid),
    .inReady(inReady), .mute(mute), .write_ready(write_ready), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .level(level), .underrunCount(underrunCount), .streaming(streaming)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [23:0] exp);
    chk({tag, "_l"}, {8'h0, writedata_left}, {8'h0, exp});
    chk({tag, "_r"}, {8'h0, writedata_right}, {8'h0, exp});
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b1; inSample = 16'h0005; mute = 1'b0; write_ready = 1'b1;
    // Reset held three cycles with valid/ready asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_inReady", 32'(inReady), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk_data("rst_data", 24'h0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_urc", 32'(underrunCount), 32'd0);
      chk("rst_streaming", 32'(streaming), 32'd0);
    end

    // Prefill: seven pushes, codec receives zeros, no pops.
    rst = 1'b0; inValid = 1'b0;
    tick();
    for (int i = 1; i <= 7; i++) begin
      inSample = 16'(i); inValid = 1'b1; #1;
      chk("pre_write", 32'(write), 32'd1);
      chk_data("pre_data", 24'h0);
      tick();
    end
    chk("pre_level7", 32'(level), 32'd7);
    chk("pre_stream7", 32'(streaming), 32'd0);
    inSample = 16'h0008;
    tick();
    chk("pre_level8", 32'(level), 32'd8);
    chk("pre_stream8", 32'(streaming), 32'd0);
    inValid = 1'b0;
    tick();
    chk("stream_on", 32'(streaming), 32'd1);
    chk("stream_lvl", 32'(level), 32'd8);
    chk_data("first_word", 24'h000100);
    tick();
    chk_data("second_word", 24'h000200);
    chk("lvl_after_pop", 32'(level), 32'd7);

    // Backpressure: fill to 16 with codec stalled.
    write_ready = 1'b0;
    for (int i = 9; i <= 17; i++) begin
      inSample = 16'(i); inValid = 1'b1;
      tick();
    end
    chk("full_level", 32'(level), 32'd16);
    chk("full_inReady", 32'(inReady), 32'd0);
    inSample = 16'hDEAD;
    tick();
    chk("no_push_full", 32'(level), 32'd16);
    inValid = 1'b0; write_ready = 1'b1; #1;
    chk_data("bp_pop_word", 24'h000200);
    tick();
    write_ready = 1'b0;
    chk("bp_level15", 32'(level), 32'd15);
    chk("bp_inReady", 32'(inReady), 32'd1);

    // Drain 3..15 in order, leaving 16 and 17.
    write_ready = 1'b1;
    for (int i = 3; i <= 15; i++) begin
      #1; chk_data("drain", {8'h00, 8'(i), 8'h00});
      tick();
    end
    chk("drain_level", 32'(level), 32'd2);

    // Sign/format: 8000 and FFFF behind 0010, 0011.
    write_ready = 1'b0; inValid = 1'b1;
    inSample = 16'h8000; tick();
    inSample = 16'hFFFF; tick();
    inValid = 1'b0; write_ready = 1'b1; #1;
    chk_data("fmt_0010", 24'h001000); tick();
    chk_data("fmt_0011", 24'h001100); tick();
    chk_data("fmt_8000", 24'h800000); tick();
    chk_data("fmt_ffff", 24'hFFFF00); tick();
    chk("empty_level", 32'(level), 32'd0);
    chk("still_stream", 32'(streaming), 32'd1);

    // Underrun: transfer with empty FIFO.
    chk("ur_write", 32'(write), 32'd1);
    chk_data("ur_data", 24'h0);
    tick();
    chk("ur_count", 32'(underrunCount), 32'd1);
    chk("ur_prefill", 32'(streaming), 32'd0);
    tick();
    chk("ur_no_recount", 32'(underrunCount), 32'd1);

    // Refill 8 in PREFILL, then back to STREAM.
    for (int i = 0; i < 8; i++) begin
      inSample = 16'h0100 + 16'(i); inValid = 1'b1;
      tick();
    end
    inValid = 1'b0;
    chk("refill_level", 32'(level), 32'd8);
    chk("refill_urc", 32'(underrunCount), 32'd1);
    tick();
    chk("restream", 32'(streaming), 32'd1);

    // Mute: pops continue, data zero; unmute takes effect same cycle.
    mute = 1'b1; #1;
    chk_data("mute_data", 24'h0);
    tick();
    chk("mute_level", 32'(level), 32'd7);
    chk_data("mute_data2", 24'h0);
    mute = 1'b0; #1;
    chk_data("unmute_data", 24'h010100);
    tick();
    // Simultaneous push and pop keeps level.
    inSample = 16'h0200; inValid = 1'b1;
    tick();
    chk("pushpop_level", 32'(level), 32'd6);
    write_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    inValid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd9);

    // Mid-operation reset.
    rst = 1'b1; #1;
    chk("midrst_inReady", 32'(inReady), 32'd0);
    tick();
    rst = 1'b0;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_stream", 32'(streaming), 32'd0);
    chk("midrst_urc", 32'(underrunCount), 32'd0);
    tick();
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_stream", 32'(streaming), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/codec_sample_writer.md
Name: codec_sample_writer

Overview:
- Playback-side counterpart of the codec capture path. Accepts mono signed N-bit samples from an upstream producer, such as a tone generator or DFT resynthesis, and buffers them in a small FIFO.
- Drives the audio_codec DAC write handshake (write / write_ready / writedata_left / writedata_right).
- Widens each sample back to the 24-bit codec format and duplicates it to both channels.
- Handles prefill, underrun, and mute so the DAC stream never stalls.

Parameters:
- N, 16, sample width; matches the DFT input sample width.
- DEPTH, 16, FIFO depth in samples; power of 2, at least 4.
- AW, $clog2(DEPTH), FIFO pointer width (derived).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous, active-high reset
- inSample  in  N  signed mono sample from producer
- inValid  in  1  inSample valid
- inReady  out  1  block can accept a sample this cycle
- mute  in  1  force DAC data to zero; FIFO still drains
- write_ready  in  1  codec DAC FIFO has space
- write  out  1  codec write strobe
- writedata_left  out  24  left DAC word
- writedata_right  out  24  right DAC word
- level  out  AW+1  current FIFO occupancy (0..DEPTH)
- underrunCount  out  16  saturating count of underrun events
- streaming  out  1  high when in STREAM state

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FIFO empty, level=0, state=PREFILL.
  - underrunCount=0, streaming=0.
  - inReady=0 while rst is high.
  - write=0 and writedata_left/right=0 while rst is high.
- Reset mid-operation discards all buffered samples. No partial state survives.
- Push:
  - inReady = ~rst & (level < DEPTH); combinational from registered level.
  - A sample is stored when inValid & inReady at a clk edge.
  - A push while full cannot occur because inReady is low.
- Codec transfer:
  - write = write_ready & ~rst; combinational.
  - A word is consumed by the codec on any cycle with write & write_ready.
  - writedata_left = writedata_right = word presented in that same cycle.
- Word format:
  - word = {sample[N-1:0], (24-N) zeros}, i.e. the sample occupies bits 23:24-N.
  - This is the exact inverse of capture truncation, so no rounding is applied.
  - If mute=1, word = 0.
- FSM states:
  - PREFILL:
    - Each accepted transfer presents word 0; no pop.
    - Transitions to STREAM at the edge where registered level >= DEPTH/2.
    - The transition is evaluated on the level value before that edge's push/pop.
  - STREAM:
    - Each accepted transfer presents the FIFO head (formatted, or 0 if mute) and pops it.
    - If an accepted transfer occurs with level==0, that is an underrun: word 0 is presented, nothing is popped, underrunCount increments (saturating at 16'hFFFF), and state goes to PREFILL at the next edge.
- Simultaneous push and pop:
  - Same cycle is legal; level stays unchanged.
  - When level==0 in STREAM, a push in the same cycle as a transfer still counts as an underrun. The pushed sample is stored, not forwarded.
- Ordering: strict FIFO; no samples are dropped or duplicated except via the explicit underrun rule.
- Pointer wrap: rd/wr pointers are AW bits and wrap modulo DEPTH. level is tracked separately and is never derived from pointers alone.
- mute:
  - Affects data only.
  - Does not change pops, FSM state, or underrun counting.
  - Takes effect in the same cycle it is asserted.
- streaming = (state==STREAM); registered.

Decomposition:
- audio_pkg:
  - CODEC_W=24 localparam.
  - typedef logic signed [CODEC_W-1:0] codec_word_t.
  - typedef enum logic {PREFILL, STREAM} wr_state_t.
  - Function to_codec_word(sample) that performs the left-justify.
- One sub-module, sample_fifo:
  - Parameterised N and DEPTH.
  - Registered pointers and level; combinational head read.
  - push/pop/full/empty.
- codec_sample_writer owns the FSM, the codec handshake, mute, and the counter.

Test Plan:
- Reset values: hold rst 3 cycles with inValid=1, write_ready=1 -> inReady=0, write=0, writedata=0, level=0, underrunCount=0, streaming=0 throughout.
- Prefill threshold (DEPTH=16): push 16'h0001..16'h0007 with write_ready=1 -> write=1, data 0, level=7, streaming=0. Push 16'h0008 -> streaming=1 next cycle. First streamed word = 24'h000100, then 24'h000200, in order.
- Backpressure: write_ready=0, push 16 samples -> level=16, inReady=0. A 17th inValid is not accepted. One cycle of write_ready=1 -> level=15, inReady=1 next cycle.
- Sign/format: push 16'h8000 and 16'hFFFF in STREAM -> writedata_left = writedata_right = 24'h800000, then 24'hFFFF00.
- Underrun: in STREAM, stop pushing and keep write_ready=1 until empty -> one cycle with data 0, underrunCount=1, streaming=0 next cycle. No further counts until STREAM is re-entered after 8 more pushes.
- Mute and mid-op reset: with mute=1 in STREAM, level decrements per transfer and data=0. Assert rst for 1 cycle with level=9 -> level=0, streaming=0, underrunCount=0 on the following cycle.
